// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : one-transaction-at-a-time arbiter for the shared RAM port
// (IF=0, DAT=1, DBG=2), with a DBG anti-starvation override.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [2:0]    gnt,
  output logic [2:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [1:0]    owner,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    LAT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LOAD   = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
  localparam logic [3:0] STARVE_THR = 4'(STARVE_LIM);

  state_t          state, state_nxt;
  logic [1:0]      owner_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      lat_cnt;
  logic [3:0]      starve_cnt;

  logic            any_req;
  logic            dbg_force;
  logic [1:0]      win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  // Winner selection: DAT > IF > DBG, unless DBG has lost too often.
  always_comb begin
    any_req   = if_req | dat_req | dbg_req;
    dbg_force = dbg_req && (starve_cnt >= STARVE_THR);
    win       = 2'd0;
    win_we    = 1'b0;
    win_addr  = if_addr;
    win_wdata = '0;
    if (dbg_force) begin
      win       = 2'd2;
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end else if (dat_req) begin
      win       = 2'd1;
      win_we    = dat_we;
      win_addr  = dat_addr;
      win_wdata = dat_wdata;
    end else if (if_req) begin
      win       = 2'd0;
      win_addr  = if_addr;
    end else if (dbg_req) begin
      win       = 2'd2;
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs depend only on registered state/owner/latched operands.
  always_comb begin
    state_nxt = state;
    gnt       = 3'b000;
    done      = 3'b000;
    busy      = 1'b1;
    mem_write = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_req) state_nxt = ACC;
      end
      ACC: begin
        gnt       = 3'b001 << owner_q;
        mem_write = we_q;
        if (we_q || (RD_LAT == 1)) state_nxt = DONE;
        else                       state_nxt = LAT;
      end
      LAT: begin
        if (lat_cnt == 2'd0) state_nxt = DONE;
      end
      DONE: begin
        done      = 3'b001 << owner_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lat_cnt    <= 2'd0;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
          end
          // A pending DBG request implies a grant this cycle, so every
          // dbg_req-high IDLE cycle is a lost or won arbitration.
          if (!dbg_req || (win == 2'd2)) starve_cnt <= 4'd0;
          else if (starve_cnt != 4'hF)   starve_cnt <= starve_cnt + 4'd1;
        end
        ACC: begin
          if (!we_q) begin
            if (RD_LAT == 1) rdata_q <= mem_rdata;
            else             lat_cnt <= LAT_LOAD;
          end
        end
        LAT: begin
          if (lat_cnt == 2'd0) rdata_q <= mem_rdata;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign owner = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scoreboard bench; instance a (RD_LAT=1,
// STARVE_LIM=2) and instance b (RD_LAT=3, STARVE_LIM=4).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  typedef struct packed {
    logic [2:0]  port;
    logic [15:0] rdata;
  } exp_t;

  logic clk;
  logic reset;

  logic        a_if_req, a_dat_req, a_dat_we, a_dbg_req, a_dbg_we;
  logic [7:0]  a_if_addr, a_dat_addr, a_dbg_addr;
  logic [15:0] a_dat_wdata, a_dbg_wdata;
  logic [2:0]  a_gnt, a_done;
  logic [15:0] a_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_busy, a_mem_write;
  logic [1:0]  a_owner;
  logic [7:0]  a_mem_addr;

  logic        b_if_req, b_dat_req, b_dat_we, b_dbg_req, b_dbg_we;
  logic [7:0]  b_if_addr, b_dat_addr, b_dbg_addr;
  logic [15:0] b_dat_wdata, b_dbg_wdata;
  logic [2:0]  b_gnt, b_done;
  logic [15:0] b_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_busy, b_mem_write;
  logic [1:0]  b_owner;
  logic [7:0]  b_mem_addr;

  logic [15:0] b_pipe0, b_pipe1;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(1), .STARVE_LIM(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr),
    .dat_req(a_dat_req), .dat_we(a_dat_we), .dat_addr(a_dat_addr), .dat_wdata(a_dat_wdata),
    .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
    .gnt(a_gnt), .done(a_done), .rdata(a_rdata), .busy(a_busy), .owner(a_owner),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_write(a_mem_write),
    .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(3), .STARVE_LIM(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .dat_req(b_dat_req), .dat_we(b_dat_we), .dat_addr(b_dat_addr), .dat_wdata(b_dat_wdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .gnt(b_gnt), .done(b_done), .rdata(b_rdata), .busy(b_busy), .owner(b_owner),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_write(b_mem_write),
    .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ram_val(input logic [7:0] a);
    return (a == 8'h05) ? 16'hABCD : {~a, a};
  endfunction

  function automatic exp_t mk(input logic [2:0] p, input logic [15:0] d);
    exp_t e;
    e.port  = p;
    e.rdata = d;
    return e;
  endfunction

  // RAM a answers within the access cycle; RAM b delivers two cycles later.
  assign a_mem_rdata = ram_val(a_mem_addr);
  always @(posedge clk) begin
    b_pipe0 <= ram_val(b_mem_addr);
    b_pipe1 <= b_pipe0;
  end
  assign b_mem_rdata = b_pipe1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_gnt(input bit sel_b, input int budget,
                          output logic [2:0] g, output int n);
    n = 0;
    g = 3'b000;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      g = sel_b ? b_gnt : a_gnt;
      if (g != 3'b000) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk(sel_b ? "b_gnt_timeout" : "a_gnt_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (a_done != 3'b000) begin
      chk("a_done_expected", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) begin
        ea = sb_a.pop_front();
        chk("a_done_port", 32'(a_done), 32'(ea.port));
        chk("a_done_rdata", 32'(a_rdata), 32'(ea.rdata));
      end
    end
    if (b_done != 3'b000) begin
      chk("b_done_expected", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        eb = sb_b.pop_front();
        chk("b_done_port", 32'(b_done), 32'(eb.port));
        chk("b_done_rdata", 32'(b_rdata), 32'(eb.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    int         n;
    logic [2:0] starve_exp [4];
    starve_exp = '{3'b010, 3'b010, 3'b100, 3'b010};

    {a_if_req, a_dat_req, a_dat_we, a_dbg_req, a_dbg_we} = '0;
    {a_if_addr, a_dat_addr, a_dbg_addr, a_dat_wdata, a_dbg_wdata} = '0;
    {b_if_req, b_dat_req, b_dat_we, b_dbg_req, b_dbg_we} = '0;
    {b_if_addr, b_dat_addr, b_dbg_addr, b_dat_wdata, b_dbg_wdata} = '0;
    reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("a_rst_ctl", 32'({a_gnt, a_done, a_busy, a_owner, a_mem_write}), 32'd0);
    chk("a_rst_mem", 32'({a_mem_addr, a_mem_wdata}), 32'd0);
    chk("a_rst_rdata", 32'(a_rdata), 32'd0);
    chk("b_rst_ctl", 32'({b_gnt, b_done, b_busy, b_owner, b_mem_write}), 32'd0);
    reset = 1'b1;

    // IF read on a (RD_LAT=1)
    @(posedge clk); #1;
    a_if_req  = 1'b1;
    a_if_addr = 8'h05;
    sb_a.push_back(mk(3'b001, 16'hABCD));
    wait_gnt(1'b0, 8, g, n);
    chk("a_if_gnt", 32'(g), 32'b001);
    chk("a_if_mem_addr", 32'(a_mem_addr), 32'h05);
    chk("a_if_no_write", 32'(a_mem_write), 32'd0);
    chk("a_if_busy", 32'(a_busy), 32'd1);
    a_if_req = 1'b0;
    @(negedge clk);
    chk("a_if_done_cycle", 32'(a_done), 32'b001);
    chk("a_if_no_write_done", 32'(a_mem_write), 32'd0);
    @(negedge clk);
    chk("a_if_back_idle", 32'({a_busy, a_gnt, a_mem_addr}), 32'd0);

    // Simultaneous IF read and DAT store: DAT first, rdata untouched
    a_if_req    = 1'b1;
    a_if_addr   = 8'h06;
    a_dat_req   = 1'b1;
    a_dat_we    = 1'b1;
    a_dat_addr  = 8'h10;
    a_dat_wdata = 16'h1234;
    sb_a.push_back(mk(3'b010, 16'hABCD));
    sb_a.push_back(mk(3'b001, ram_val(8'h06)));
    wait_gnt(1'b0, 8, g, n);
    chk("a_st_gnt", 32'(g), 32'b010);
    chk("a_st_write", 32'(a_mem_write), 32'd1);
    chk("a_st_addr", 32'(a_mem_addr), 32'h10);
    chk("a_st_wdata", 32'(a_mem_wdata), 32'h1234);
    chk("a_st_owner", 32'(a_owner), 32'd1);
    a_dat_req = 1'b0;
    a_dat_we  = 1'b0;
    @(negedge clk);
    chk("a_st_write_once", 32'(a_mem_write), 32'd0);
    wait_gnt(1'b0, 8, g, n);
    chk("a_if2_gnt", 32'(g), 32'b001);
    chk("a_if2_spacing", 32'(n), 32'd2);
    chk("a_if2_addr", 32'(a_mem_addr), 32'h06);
    a_if_req = 1'b0;
    @(negedge clk);

    // Starvation on a (STARVE_LIM=2): DAT, DAT, DBG, DAT
    a_dat_req  = 1'b1;
    a_dat_we   = 1'b0;
    a_dat_addr = 8'h30;
    a_dbg_req  = 1'b1;
    a_dbg_we   = 1'b0;
    a_dbg_addr = 8'h40;
    for (int k = 0; k < 4; k++)
      sb_a.push_back(mk(starve_exp[k], ram_val(starve_exp[k] == 3'b100 ? 8'h40 : 8'h30)));
    for (int k = 0; k < 4; k++) begin
      wait_gnt(1'b0, 8, g, n);
      chk($sformatf("a_starve_gnt%0d", k), 32'(g), 32'(starve_exp[k]));
      if (k > 0) chk($sformatf("a_starve_spacing%0d", k), 32'(n), 32'd3);
    end
    a_dat_req = 1'b0;
    a_dbg_req = 1'b0;
    repeat (2) @(negedge clk);

    // DBG read on b (RD_LAT=3)
    b_dbg_req  = 1'b1;
    b_dbg_we   = 1'b0;
    b_dbg_addr = 8'h20;
    sb_b.push_back(mk(3'b100, ram_val(8'h20)));
    wait_gnt(1'b1, 8, g, n);
    chk("b_dbg_gnt", 32'(g), 32'b100);
    chk("b_dbg_acc_addr", 32'(b_mem_addr), 32'h20);
    b_dbg_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("b_dbg_done_t%0d", k), 32'(b_done), (k == 3) ? 32'b100 : 32'd0);
      if (k < 3) begin
        chk($sformatf("b_dbg_lat_addr%0d", k), 32'(b_mem_addr), 32'h20);
        chk($sformatf("b_dbg_lat_nowr%0d", k), 32'(b_mem_write), 32'd0);
      end
    end
    @(negedge clk);

    // Reset in the middle of a b read: no done may follow
    b_if_req  = 1'b1;
    b_if_addr = 8'h07;
    wait_gnt(1'b1, 8, g, n);
    chk("b_abort_gnt", 32'(g), 32'b001);
    b_if_req = 1'b0;
    @(negedge clk);
    chk("b_abort_in_lat", 32'(b_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("b_abort_ctl", 32'({b_gnt, b_done, b_busy, b_owner, b_mem_write}), 32'd0);
    chk("b_abort_mem", 32'({b_mem_addr, b_mem_wdata}), 32'd0);
    chk("b_abort_rdata", 32'(b_rdata), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fresh IF read on b, request dropped the cycle after grant
    b_if_req  = 1'b1;
    b_if_addr = 8'h08;
    sb_b.push_back(mk(3'b001, ram_val(8'h08)));
    wait_gnt(1'b1, 8, g, n);
    chk("b_drop_gnt", 32'(g), 32'b001);
    @(negedge clk);
    b_if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_drop_done", 32'(b_done), 32'b001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b_drop_quiet%0d", k), 32'({b_busy, b_gnt, b_done}), 32'd0);
    end

    chk("a_sb_drained", 32'(sb_a.size()), 32'd0);
    chk("b_sb_drained", 32'(sb_b.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
